// File: rtl/nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_seq_adder
// Purpose  : Multi-cycle adder. A single external 4-bit ripple-carry slice is
//            reused, one nibble per clock, LSB nibble first. The carry between
//            nibbles is kept in a register. The full result appears on sum
//            only when the last nibble is done.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            start      - begin an addition (only looked at in IDLE)
//            a, b, cin  - operands and carry-in (W = 4*NUM_NIBBLES bits)
//            slice_a/b  - nibble operands sent to the external slice
//            slice_cin  - carry sent to the external slice
//            slice_sum  - combinational nibble sum returned by the slice
//            slice_cout - combinational carry returned by the slice
//            busy       - high in ADD and DONE
//            done       - one-cycle pulse; the result is valid in this cycle
//            sum/cout/ovf - registered result, carry-out and signed overflow
// Revision : 1.0 - initial release
// ============================================================================
module nibble_seq_adder #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [4*NUM_NIBBLES-1:0] a,
  input  logic [4*NUM_NIBBLES-1:0] b,
  input  logic                     cin,
  output logic [3:0]               slice_a,
  output logic [3:0]               slice_b,
  output logic                     slice_cin,
  input  logic [3:0]               slice_sum,
  input  logic                     slice_cout,
  output logic                     busy,
  output logic                     done,
  output logic [4*NUM_NIBBLES-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  localparam int W = 4 * NUM_NIBBLES;
  // The index needs at least one bit, even when there is a single nibble.
  localparam int c_IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_NIBBLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ADD  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [W-1:0]       op_a_q, op_a_d;
  logic [W-1:0]       op_b_q, op_b_d;
  logic [W-1:0]       work_q, work_d;
  logic [c_IDX_W-1:0] idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  // Bit offset of the nibble being worked on (idx * 4).
  logic [c_IDX_W+1:0] nib_ofs;
  assign nib_ofs = {idx_q, 2'b00};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      work_q  <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    work_d  = work_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      c_IDLE: begin
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = c_ADD;
        end
      end

      c_ADD: begin
        work_d[nib_ofs +: 4] = slice_sum;
        carry_d              = slice_cout;
        idx_d                = idx_q + c_IDX_ONE;
        if (idx_q == c_LAST_IDX) begin
          // Publish the whole result at once, including the nibble being
          // written on this edge, so partial sums are never seen on sum.
          // The final slice carry goes only to cout; it does not wrap into
          // nibble 0.
          sum_d   = work_d;
          cout_d  = slice_cout;
          ovf_d   = (op_a_q[W-1] == op_b_q[W-1]) && (work_d[W-1] != op_a_q[W-1]);
          idx_d   = '0;
          state_d = c_DONE;
        end
      end

      c_DONE: begin
        state_d = c_IDLE;
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs. The slice is fed only from registers, so there is no
  // combinational path from the inputs to the slice outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    slice_a   = 4'h0;
    slice_b   = 4'h0;
    slice_cin = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      c_ADD: begin
        slice_a   = op_a_q[nib_ofs +: 4];
        slice_b   = op_b_q[nib_ofs +: 4];
        slice_cin = carry_q;
        busy      = 1'b1;
      end
      c_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_seq_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_seq_adder
// Purpose  : Self-checking bench for nibble_seq_adder (NUM_NIBBLES = 4).
//            An arithmetic 4-bit slice is attached to the DUT. The expected
//            results come from whole-word arithmetic on a, b and cin.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_seq_adder;

  localparam int NUM_NIBBLES = 4;
  localparam int W = 4 * NUM_NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic [3:0]   slice_a, slice_b, slice_sum;
  logic         slice_cin, slice_cout;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected result of the last completed addition (the model).
  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  always #5 clk = ~clk;

  // External 4-bit ripple-carry slice
  assign {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0, slice_cin};

  nibble_seq_adder #(.NUM_NIBBLES(NUM_NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .slice_a   (slice_a),
    .slice_b   (slice_b),
    .slice_cin (slice_cin),
    .slice_sum (slice_sum),
    .slice_cout(slice_cout),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a plain word-wide addition.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
    logic [W:0] full;
    full     = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    // Signed overflow: both operands have the same sign and the result sign differs
    exp_ovf  = (ma[W-1] == mb[W-1]) && (full[W-1] != ma[W-1]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run one addition and check the latency, the handshake, and the result.
  // If hold_start is set, start stays high during ADD with a corrupted 'a'.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc, input bit hold_start, input string tag);
    int  edges;
    bit  seen;
    logic [W-1:0] prev_sum;
    // Wait until the DUT is in IDLE (at most a few cycles).
    for (int i = 0; i < 4 && busy; i++) tick();
    chk({tag, ":idle_before_start"}, {31'b0, busy}, 32'd0);
    prev_sum = exp_sum;
    a = va; b = vb; cin = vc; start = 1'b1;
    model(va, vb, vc);
    tick();                                   // edge that samples start
    if (hold_start) a = 16'hAAAA;
    else begin
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
    end
    edges = 0;
    seen  = 0;
    while (!seen && edges < 10) begin
      // While the add is running, sum must still show the previous result.
      if (!done) chk({tag, ":sum_hold"}, {16'b0, sum}, {16'b0, prev_sum});
      if (done) seen = 1;
      else begin
        tick();
        edges++;
      end
    end
    // After the start edge, ADD takes NUM_NIBBLES cycles. DONE is then the
    // (NUM_NIBBLES+1)th cycle.
    chk({tag, ":done_latency"}, edges, NUM_NIBBLES);
    chk({tag, ":busy_in_done"}, {31'b0, busy}, 32'd1);
    chk({tag, ":sum"}, {16'b0, sum}, {16'b0, exp_sum});
    chk({tag, ":cout"}, {31'b0, cout}, {31'b0, exp_cout});
    chk({tag, ":ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
    start = 1'b0;
    tick();
    chk({tag, ":done_one_cycle"}, {31'b0, done}, 32'd0);
    chk({tag, ":busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, ":slice_idle"}, {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
    chk({tag, ":sum_after"}, {16'b0, sum}, {16'b0, exp_sum});
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0; start = 1'b1; a = '0; b = '0; cin = 1'b0;
    // Reset must win over start on the same edge.
    tick(); tick();
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_outs", {15'b0, sum, cout, ovf}, 32'd0);
    chk("reset_slice", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
    start = 1'b0; rst_n = 1'b1;
    tick();

    run_op(16'h0003, 16'h0001, 1'b0, 0, "small");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, "ripple");
    run_op(16'h7FFF, 16'h0001, 1'b0, 0, "ovf");
    // Starts in the IDLE cycle right after DONE (run_op leaves us there).
    run_op(16'h1234, 16'h4321, 1'b1, 0, "b2b");
    run_op(16'h8000, 16'h8000, 1'b0, 0, "neg_ovf");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "all_ones");

    // start held high during ADD: operands must not be re-latched, and
    // there must be a single done pulse.
    run_op(16'h1111, 16'h2222, 1'b0, 1, "hold_start");
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcount++;
      tick();
    end
    chk("hold_start:extra_done", dcount, 0);

    // Reset in the second ADD cycle aborts the addition.
    a = 16'h5555; b = 16'h3333; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();                                   // now in the second ADD cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_outs", {15'b0, sum, cout, ovf}, 32'd0);
    chk("abort_slice", {23'b0, slice_a, slice_b, slice_cin}, 32'd0);
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    chk("abort_no_done", dcount, 0);
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, "after_abort");

    // Random operands, with a random number of idle cycles between them
    // (possibly none).
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (k % 4 == 0) rb = ~ra;               // long carry chains
      run_op(ra, rb, 1'($urandom), 0, "rand");
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
